// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALU-op codes, select constants and control state types
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_BEQ   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_ANDI  = 3'b011;
    localparam logic [2:0] ALU_ORI   = 3'b100;

    localparam logic [1:0] SRC_B_REG      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_IMM      = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
`ifdef ILLEGAL_OP_TRAP_EN
        , S_TRAP   = 4'd12
`endif
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/control_output_decode.sv
// rtl/control_output_decode.sv - combinational state-to-control-word ROM
module control_output_decode
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        case (state)
            S_FETCH: begin
                // IR load and PC increment commit only on the cycle memory delivers
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.pc_source = PC_SRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRC_B_IMM_SHL2;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_REG;
                ctrl.alu_op        = ALU_BEQ;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_ANDI: ctrl.alu_op = ALU_ANDI;
                    OP_ORI:  ctrl.alu_op = ALU_ORI;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM; ILLEGAL_OP_TRAP_EN enables the illegal-opcode trap
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:              next_state = S_MEM_ADDR;
                    OP_RTYPE:                  next_state = S_R_EXEC;
                    OP_BEQ:                    next_state = S_BRANCH;
                    OP_J:                      next_state = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:  next_state = S_I_EXEC;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:                   next_state = S_TRAP;
`else
                    default:                   next_state = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) next_state = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
            S_R_EXEC:   next_state = S_R_WB;
            S_I_EXEC:   next_state = S_I_WB;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:     next_state = S_TRAP;
`endif
            default:    next_state = S_FETCH;
        endcase
    end

    control_output_decode u_decode (
        .state     (state),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // Reset squashes every strobe immediately so an aborted instruction writes nothing
    assign ctrl = reset ? '0 : ctrl_raw;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset)                                           illegal_q <= 1'b0;
        else if (state == S_DECODE && next_state == S_TRAP)  illegal_q <= 1'b1;
    end

    assign illegal_op = illegal_q & ~reset;
`endif

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control state machine for the multi-cycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and write-back over several clocks, and drives the datapath mux selects and write strobes. It also produces the 3-bit `alu_op` consumed by the existing ALU control decoder. All memory accesses wait on a single-port memory `mem_ready` handshake.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `opcode`  in  6  instruction[31:26] from the instruction register
- `mem_ready`  in  1  memory completed the current read/write this cycle
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`  out  1 each  datapath strobes/selects
- `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  register-file and ALU-A selects
- `alu_src_b`  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `alu_op`  out  3  to ALU control
- `illegal_op`  out  1  sticky trap flag (only when the macro is defined)

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101.
- States, 4-bit encoding:
  - FETCH 0: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00. When mem_ready=1: ir_write=1, pc_write=1 → DECODE. Otherwise stay in FETCH with strobes low.
  - DECODE 1: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target). Next state by opcode: lw/sw→MEM_ADDR, R→R_EXEC, beq→BRANCH, j→JUMP, addi/andi/ori→I_EXEC, other→see Configuration.
  - MEM_ADDR 2: alu_src_a=1, alu_src_b=10, alu_op=ADD. Goes to MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD 3: mem_read=1, i_or_d=1. Advances to MEM_WB when mem_ready=1.
  - MEM_WB 4: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
  - MEM_WR 5: mem_write=1, i_or_d=1. Goes to FETCH when mem_ready=1.
  - R_EXEC 6: alu_src_a=1, alu_src_b=00, alu_op=RTYPE → R_WB.
  - R_WB 7: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
  - BRANCH 8: alu_src_a=1, alu_src_b=00, alu_op=BEQ, pc_write_cond=1, pc_source=01 → FETCH.
  - JUMP 9: pc_write=1, pc_source=10 → FETCH.
  - I_EXEC 10: alu_src_a=1, alu_src_b=10, alu_op=ADD/ANDI/ORI by opcode → I_WB.
  - I_WB 11: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
  - TRAP 12: all strobes 0. Stays in TRAP until reset.
- Any signal not listed for a state is 0.
- `alu_op` encodings: ADD 000, BEQ 001, RTYPE 010, ANDI 011, ORI 100. Any unlisted state outputs ADD.
- Outputs are a Moore decode of the state. The only exception is the FETCH strobes `ir_write`/`pc_write`, which are gated by `mem_ready`.
- The `opcode` captured in I_EXEC is used in I_EXEC directly; the IR is stable after DECODE.

## Timing
- State register updates on rising `clk`.
- The cycle after reset sampled high, the state is FETCH.
- While `reset`=1, every output is forced to 0 combinationally, `illegal_op` clears, and `alu_op`=000.
- Reset asserted mid-instruction aborts the instruction with no further write strobes.
- Latency with mem_ready tied to 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi/andi/ori: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Write strobes fire only once, on the ready cycle.
- `mem_write` and `mem_read` are never both 1.
- `reg_write` is asserted for exactly one cycle per instruction that writes a register.

## Configuration
- `ILLEGAL_OP_TRAP_EN` defined:
  - An undefined opcode in DECODE moves to TRAP and sets `illegal_op`=1 (sticky until reset).
- `ILLEGAL_OP_TRAP_EN` undefined:
  - An undefined opcode returns to FETCH as a NOP; the PC has already advanced.
  - The TRAP state and `illegal_op` port are absent.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants
  - `alu_op` encodings (shared with ALU control)
  - the state enum/localparams
  - `alu_src_b` and `pc_source` select constants
- One natural sub-module, `control_output_decode`: combinational state→output ROM. The top level keeps the state register and next-state logic.

## Test plan
- Reset held 2 cycles, then released → all outputs 0 during reset. State is FETCH, mem_read=1 on the first cycle after release.
- lw (100011), mem_ready=1 → states 0,1,2,3,4. mem_to_reg=1 and reg_write=1 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEM_WR → mem_write held 4 cycles. Returns to FETCH after the ready cycle; no reg_write.
- R-type, then beq, then j back to back → alu_op 010 in R_EXEC, 001 in BRANCH. pc_write_cond=1 for one cycle; pc_source=10 with pc_write=1 in JUMP.
- ori (001101) → I_EXEC alu_op=100, alu_src_b=10, then reg_write=1 with reg_dst=0.
- Opcode 111111:
  - with `ILLEGAL_OP_TRAP_EN` → TRAP, illegal_op=1 held until reset.
  - without it → back to FETCH after DECODE, no writes.
